spi_minion_arbiter: RTL and testbench

// - Shares one SPI minion adapter between NUM_REQ on-chip requesters.
// - Upstream (chip->master): round-robin arbitration of requester messages into the adapter

---
 rtl/spi_minion_arbiter_if.sv | 54 +++++
 rtl/spi_minion_arbiter.sv | 160 ++++++++++++++++
 tb/tb_spi_minion_arbiter.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/spi_minion_arbiter_if.sv
// ----------------------------------------------------------------------------
// spi_minion_arbiter_if
// Bundles every handshake/bus signal between the SPI minion arbiter, its
// on-chip requesters and the shared SPI minion adapter.
//
// Parameters
//   nbits   : adapter word width including the 2 SPI control bits
//   NUM_REQ : number of requesters sharing the adapter
//
// Signals (DW = nbits-2)
//   req_recv_val/rdy/msg : requesters -> arbiter (msg flattened, i owns [i*DW +: DW])
//   adp_recv_val/rdy/msg : arbiter -> adapter recv port
//   adp_send_val/rdy/msg : adapter send port -> arbiter
//   req_send_val/rdy/msg : arbiter -> requesters (msg shared by all requesters)
//   bad_addr             : pulse when a downstream message is dropped
//
// Modports
//   master : the arbiter itself
//   slave  : the environment around it (requesters + adapter)
// ----------------------------------------------------------------------------
interface spi_minion_arbiter_if #(
    parameter int nbits   = 8,
    parameter int NUM_REQ = 2
);
    localparam int DW = nbits - 2;

    logic [NUM_REQ-1:0]    req_recv_val;
    logic [NUM_REQ-1:0]    req_recv_rdy;
    logic [NUM_REQ*DW-1:0] req_recv_msg;
    logic                  adp_recv_val;
    logic                  adp_recv_rdy;
    logic [DW-1:0]         adp_recv_msg;
    logic                  adp_send_val;
    logic                  adp_send_rdy;
    logic [DW-1:0]         adp_send_msg;
    logic [NUM_REQ-1:0]    req_send_val;
    logic [NUM_REQ-1:0]    req_send_rdy;
    logic [DW-1:0]         req_send_msg;
    logic                  bad_addr;

    modport master (
        input  req_recv_val, req_recv_msg, adp_recv_rdy,
        input  adp_send_val, adp_send_msg, req_send_rdy,
        output req_recv_rdy, adp_recv_val, adp_recv_msg,
        output adp_send_rdy, req_send_val, req_send_msg, bad_addr
    );

    modport slave (
        output req_recv_val, req_recv_msg, adp_recv_rdy,
        output adp_send_val, adp_send_msg, req_send_rdy,
        input  req_recv_rdy, adp_recv_val, adp_recv_msg,
        input  adp_send_rdy, req_send_val, req_send_msg, bad_addr
    );
endinterface

// File: rtl/spi_minion_arbiter.sv
// ----------------------------------------------------------------------------
// spi_minion_arbiter
// Shares one SPI minion adapter between NUM_REQ on-chip requesters.
//   Upstream  : round-robin arbitration of requester messages into a one-entry
//               buffer feeding the adapter recv port; the winning requester
//               index replaces the top AW message bits.
//   Downstream: adapter send-port messages go through a one-entry buffer and
//               are presented to the requester named by their top AW bits.
//               Messages addressing a non-existent requester are consumed and
//               reported with a one-cycle bad_addr pulse.
// The two directions share no state.
//
// Ports
//   clk   : clock, all state updates on posedge
//   reset : synchronous, active-high
//   bus   : spi_minion_arbiter_if.master (all handshake/bus signals)
// ----------------------------------------------------------------------------
module spi_minion_arbiter #(
    parameter int nbits   = 8,
    parameter int NUM_REQ = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    spi_minion_arbiter_if.master bus
);
    localparam int DW = nbits - 2;
    localparam int AW = $clog2(NUM_REQ);

    // ------------------------------------------------------------------
    // Upstream: requesters -> adapter
    // ------------------------------------------------------------------
    logic          up_full;
    logic [DW-1:0] up_msg;
    logic [AW-1:0] rr_ptr;
    logic          up_found;
    logic [AW-1:0] up_gidx;
    logic          up_grant;
    logic [AW:0]   up_idx;
    logic [AW-1:0] up_cand;
    logic [DW-1:0] up_win_msg;
    logic [AW-1:0] unused_win_addr;

    // Round-robin search starting at rr_ptr; up_idx has one spare bit so the
    // wrap test cannot overflow.
    always_comb begin
        up_found = 1'b0;
        up_gidx  = '0;
        up_idx   = '0;
        up_cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            up_idx = {1'b0, rr_ptr} + (AW+1)'(k);
            if (up_idx >= (AW+1)'(NUM_REQ)) begin
                up_idx = up_idx - (AW+1)'(NUM_REQ);
            end
            up_cand = up_idx[AW-1:0];
            if (!up_found && bus.req_recv_val[up_cand]) begin
                up_found = 1'b1;
                up_gidx  = up_cand;
            end
        end
    end

    assign up_win_msg      = bus.req_recv_msg[int'(up_gidx)*DW +: DW];
    // The requester's own top bits are overwritten by the tag.
    assign unused_win_addr = up_win_msg[DW-1 -: AW];

    // Grant only when the buffer is empty or draining this cycle.
    assign up_grant = up_found && (!up_full || bus.adp_recv_rdy) && !reset;

    always_comb begin
        bus.req_recv_rdy = '0;
        if (up_grant) begin
            bus.req_recv_rdy[up_gidx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            up_full <= 1'b0;
            rr_ptr  <= '0;
        end else if (up_grant) begin
            up_full <= 1'b1;
            rr_ptr  <= (up_gidx == AW'(NUM_REQ-1)) ? '0 : up_gidx + AW'(1);
        end else if (bus.adp_recv_rdy) begin
            up_full <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (up_grant) begin
            up_msg <= {up_gidx, up_win_msg[DW-AW-1:0]};
        end
    end

    assign bus.adp_recv_val = up_full;
    assign bus.adp_recv_msg = up_msg;

    // ------------------------------------------------------------------
    // Downstream: adapter -> requesters
    // ------------------------------------------------------------------
    logic          dn_full;
    logic [DW-1:0] dn_msg;
    logic [AW-1:0] dn_dst;
    logic [AW-1:0] dn_addr;
    logic          dn_addr_ok;
    logic          dn_fire;
    logic          dn_rdy;
    logic          dn_accept;
    logic          bad_addr_q;

    assign dn_addr = bus.adp_send_msg[DW-1 -: AW];

    // With a power-of-two requester count every address is valid.
    generate
        if ((1 << AW) == NUM_REQ) begin : g_addr_pow2
            assign dn_addr_ok = 1'b1;
        end else begin : g_addr_range
            assign dn_addr_ok = (dn_addr < AW'(NUM_REQ));
        end
    endgenerate

    // Only the addressed requester's rdy matters: a stalled target blocks
    // everything behind it.
    assign dn_fire   = dn_full && bus.req_send_rdy[dn_dst];
    assign dn_rdy    = (!dn_full || dn_fire) && !reset;
    assign dn_accept = bus.adp_send_val && dn_rdy;

    always_ff @(posedge clk) begin
        if (reset) begin
            dn_full    <= 1'b0;
            bad_addr_q <= 1'b0;
        end else begin
            bad_addr_q <= dn_accept && !dn_addr_ok;
            if (dn_accept && dn_addr_ok) begin
                dn_full <= 1'b1;
            end else if (dn_fire) begin
                dn_full <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (dn_accept && dn_addr_ok) begin
            dn_msg <= bus.adp_send_msg;
            dn_dst <= dn_addr;
        end
    end

    always_comb begin
        bus.req_send_val = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_send_val[i] = dn_full && (dn_dst == AW'(i));
        end
    end

    assign bus.adp_send_rdy = dn_rdy;
    assign bus.req_send_msg = dn_msg;
    assign bus.bad_addr     = bad_addr_q;

endmodule

// File: tb/tb_spi_minion_arbiter.sv
// ----------------------------------------------------------------------------
// tb_spi_minion_arbiter
// Directed bench for spi_minion_arbiter: a NUM_REQ=4 instance for arbitration,
// tagging, backpressure, routing and reset; a NUM_REQ=3 instance for dropped
// addresses and a random downstream scoreboard.
// ----------------------------------------------------------------------------
module tb_spi_minion_arbiter;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    spi_minion_arbiter_if #(.nbits(8), .NUM_REQ(4)) if4 ();
    spi_minion_arbiter_if #(.nbits(8), .NUM_REQ(3)) if3 ();

    spi_minion_arbiter #(.nbits(8), .NUM_REQ(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (if4)
    );

    spi_minion_arbiter #(.nbits(8), .NUM_REQ(3)) dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (if3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic init_inputs();
        if4.req_recv_val = '0; if4.req_recv_msg = '0; if4.adp_recv_rdy = 1'b0;
        if4.adp_send_val = 1'b0; if4.adp_send_msg = '0; if4.req_send_rdy = '0;
        if3.req_recv_val = '0; if3.req_recv_msg = '0; if3.adp_recv_rdy = 1'b0;
        if3.adp_send_val = 1'b0; if3.adp_send_msg = '0; if3.req_send_rdy = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        if4.req_recv_val = 4'hF; if4.adp_recv_rdy = 1'b1;
        if4.adp_send_val = 1'b1; if4.adp_send_msg = 6'h15; if4.req_send_rdy = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (if4.req_recv_rdy !== 4'b0000) begin errors++; $display("FAIL reset_req_recv_rdy: got %b expected 0000", if4.req_recv_rdy); end
        checks++; if (if4.adp_send_rdy !== 1'b0) begin errors++; $display("FAIL reset_adp_send_rdy: got %b expected 0", if4.adp_send_rdy); end
        checks++; if (if4.adp_recv_val !== 1'b0) begin errors++; $display("FAIL reset_adp_recv_val: got %b expected 0", if4.adp_recv_val); end
        checks++; if (if4.req_send_val !== 4'b0000) begin errors++; $display("FAIL reset_req_send_val: got %b expected 0000", if4.req_send_val); end
        checks++; if (if4.bad_addr !== 1'b0) begin errors++; $display("FAIL reset_bad_addr4: got %b expected 0", if4.bad_addr); end
        checks++; if (if3.bad_addr !== 1'b0) begin errors++; $display("FAIL reset_bad_addr3: got %b expected 0", if3.bad_addr); end
        init_inputs();
        reset = 1'b0;
        @(posedge clk); #1;
        checks++; if (if4.adp_recv_val !== 1'b0) begin errors++; $display("FAIL reset_idle_val: got %b expected 0", if4.adp_recv_val); end
    endtask

    // rr_ptr starts at 0, so grants must go 0,1,2,3,0.
    task automatic test_round_robin();
        logic [5:0] exp_msg;
        logic [3:0] exp_rdy;
        for (int i = 0; i < 4; i++) if4.req_recv_msg[i*6 +: 6] = 6'(i + 1);
        if4.req_recv_val = 4'hF;
        if4.adp_recv_rdy = 1'b1;
        #1;
        checks++; if (if4.req_recv_rdy !== 4'b0001) begin errors++; $display("FAIL rr_first_grant: got %b expected 0001", if4.req_recv_rdy); end
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            exp_msg = 6'(((k % 4) << 4) | ((k % 4) + 1));
            exp_rdy = 4'(1 << ((k + 1) % 4));
            checks++; if (if4.adp_recv_val !== 1'b1) begin errors++; $display("FAIL rr_val[%0d]: got %b expected 1", k, if4.adp_recv_val); end
            checks++; if (if4.adp_recv_msg !== exp_msg) begin errors++; $display("FAIL rr_msg[%0d]: got %h expected %h", k, if4.adp_recv_msg, exp_msg); end
            checks++; if (if4.req_recv_rdy !== exp_rdy) begin errors++; $display("FAIL rr_rdy[%0d]: got %b expected %b", k, if4.req_recv_rdy, exp_rdy); end
        end
        if4.req_recv_val = 4'h0;
        @(posedge clk); #1;
        checks++; if (if4.adp_recv_val !== 1'b0) begin errors++; $display("FAIL rr_drain: got %b expected 0", if4.adp_recv_val); end
    endtask

    task automatic test_tagging();
        if4.req_recv_msg[2*6 +: 6] = 6'h3F;
        if4.req_recv_val = 4'b0100;
        #1;
        checks++; if (if4.req_recv_rdy !== 4'b0100) begin errors++; $display("FAIL tag_rdy: got %b expected 0100", if4.req_recv_rdy); end
        @(posedge clk); #1;
        if4.req_recv_val = 4'h0;
        checks++; if (if4.adp_recv_val !== 1'b1) begin errors++; $display("FAIL tag_val: got %b expected 1", if4.adp_recv_val); end
        checks++; if (if4.adp_recv_msg !== 6'h2F) begin errors++; $display("FAIL tag_msg: got %h expected 2f", if4.adp_recv_msg); end
        @(posedge clk); #1;
        checks++; if (if4.adp_recv_val !== 1'b0) begin errors++; $display("FAIL tag_drain: got %b expected 0", if4.adp_recv_val); end
    endtask

    // rr_ptr is 3 here: requester 0 wins first, then 1, then 0 again.
    task automatic test_backpressure();
        logic [5:0] exp_msg [2];
        logic [3:0] exp_rdy [2];
        exp_msg[0] = 6'h1A; exp_msg[1] = 6'h05;
        exp_rdy[0] = 4'b0001; exp_rdy[1] = 4'b0010;
        if4.adp_recv_rdy = 1'b0;
        if4.req_recv_msg[0 +: 6] = 6'h05;
        if4.req_recv_msg[6 +: 6] = 6'h0A;
        if4.req_recv_val = 4'b0011;
        #1;
        checks++; if (if4.req_recv_rdy !== 4'b0001) begin errors++; $display("FAIL bp_first_rdy: got %b expected 0001", if4.req_recv_rdy); end
        @(posedge clk); #1;
        for (int s = 0; s < 3; s++) begin
            @(posedge clk); #1;
            checks++; if (if4.req_recv_rdy !== 4'b0000) begin errors++; $display("FAIL bp_stall_rdy[%0d]: got %b expected 0000", s, if4.req_recv_rdy); end
            checks++; if (if4.adp_recv_val !== 1'b1 || if4.adp_recv_msg !== 6'h05) begin errors++; $display("FAIL bp_stall_msg[%0d]: got val %b msg %h expected 1 05", s, if4.adp_recv_val, if4.adp_recv_msg); end
        end
        if4.adp_recv_rdy = 1'b1;
        #1;
        checks++; if (if4.req_recv_rdy !== 4'b0010) begin errors++; $display("FAIL bp_resume_rdy: got %b expected 0010", if4.req_recv_rdy); end
        for (int j = 0; j < 2; j++) begin
            @(posedge clk); #1;
            checks++; if (if4.adp_recv_val !== 1'b1 || if4.adp_recv_msg !== exp_msg[j]) begin errors++; $display("FAIL bp_flow_msg[%0d]: got val %b msg %h expected 1 %h", j, if4.adp_recv_val, if4.adp_recv_msg, exp_msg[j]); end
            checks++; if (if4.req_recv_rdy !== exp_rdy[j]) begin errors++; $display("FAIL bp_flow_rdy[%0d]: got %b expected %b", j, if4.req_recv_rdy, exp_rdy[j]); end
        end
        if4.req_recv_val = 4'h0;
        @(posedge clk); #1;
        checks++; if (if4.adp_recv_val !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b expected 0", if4.adp_recv_val); end
    endtask

    task automatic test_routing();
        if4.req_send_rdy = 4'b1101;
        if4.adp_send_msg = 6'h15;
        if4.adp_send_val = 1'b1;
        #1;
        checks++; if (if4.adp_send_rdy !== 1'b1) begin errors++; $display("FAIL route_empty_rdy: got %b expected 1", if4.adp_send_rdy); end
        @(posedge clk); #1;
        if4.adp_send_msg = 6'h2A;
        for (int s = 0; s < 2; s++) begin
            #1;
            checks++; if (if4.req_send_val !== 4'b0010 || if4.req_send_msg !== 6'h15) begin errors++; $display("FAIL route_hold[%0d]: got val %b msg %h expected 0010 15", s, if4.req_send_val, if4.req_send_msg); end
            checks++; if (if4.adp_send_rdy !== 1'b0) begin errors++; $display("FAIL route_block_rdy[%0d]: got %b expected 0", s, if4.adp_send_rdy); end
            if (s == 0) begin @(posedge clk); #1; end
        end
        if4.req_send_rdy = 4'b1111;
        #1;
        checks++; if (if4.adp_send_rdy !== 1'b1) begin errors++; $display("FAIL route_fire_rdy: got %b expected 1", if4.adp_send_rdy); end
        @(posedge clk); #1;
        if4.adp_send_val = 1'b0;
        checks++; if (if4.req_send_val !== 4'b0100 || if4.req_send_msg !== 6'h2A) begin errors++; $display("FAIL route_next: got val %b msg %h expected 0100 2a", if4.req_send_val, if4.req_send_msg); end
        @(posedge clk); #1;
        checks++; if (if4.req_send_val !== 4'b0000) begin errors++; $display("FAIL route_empty: got %b expected 0000", if4.req_send_val); end
    endtask

    task automatic test_reset_midop();
        if4.adp_recv_rdy = 1'b0;
        if4.req_recv_msg[0 +: 6] = 6'h07;
        if4.req_recv_val = 4'b0001;
        if4.req_send_rdy = 4'b0000;
        if4.adp_send_msg = 6'h30;
        if4.adp_send_val = 1'b1;
        @(posedge clk); #1;
        if4.req_recv_val = 4'h0;
        if4.adp_send_val = 1'b0;
        checks++; if (if4.adp_recv_val !== 1'b1 || if4.req_send_val !== 4'b1000) begin errors++; $display("FAIL midop_full: got up %b dn %b expected 1 1000", if4.adp_recv_val, if4.req_send_val); end
        reset = 1'b1;
        @(posedge clk); #1;
        checks++; if (if4.adp_recv_val !== 1'b0 || if4.req_send_val !== 4'b0000) begin errors++; $display("FAIL midop_reset: got up %b dn %b expected 0 0000", if4.adp_recv_val, if4.req_send_val); end
        reset = 1'b0;
        if4.adp_recv_rdy = 1'b1;
        @(posedge clk); #1;
        checks++; if (if4.adp_recv_val !== 1'b0 || if4.req_send_val !== 4'b0000) begin errors++; $display("FAIL midop_discard: got up %b dn %b expected 0 0000", if4.adp_recv_val, if4.req_send_val); end
    endtask

    task automatic test_bad_addr();
        if3.req_send_rdy = 3'b111;
        if3.adp_send_msg = 6'h35;
        if3.adp_send_val = 1'b1;
        #1;
        checks++; if (if3.adp_send_rdy !== 1'b1) begin errors++; $display("FAIL bad_accept: got %b expected 1", if3.adp_send_rdy); end
        @(posedge clk); #1;
        if3.adp_send_val = 1'b0;
        checks++; if (if3.bad_addr !== 1'b1) begin errors++; $display("FAIL bad_pulse: got %b expected 1", if3.bad_addr); end
        checks++; if (if3.req_send_val !== 3'b000) begin errors++; $display("FAIL bad_no_val: got %b expected 000", if3.req_send_val); end
        @(posedge clk); #1;
        checks++; if (if3.bad_addr !== 1'b0) begin errors++; $display("FAIL bad_one_cycle: got %b expected 0", if3.bad_addr); end
        checks++; if (if3.req_send_val !== 3'b000) begin errors++; $display("FAIL bad_no_val2: got %b expected 000", if3.req_send_val); end
    endtask

    // Random downstream traffic: every accepted in-range message must show up
    // once, in order, at the requester named by its top bits.
    task automatic test_random_scoreboard();
        logic [5:0] q [$];
        logic       bad_exp;
        logic [2:0] exp_val;
        bad_exp = 1'b0;
        for (int c = 0; c < 340; c++) begin
            checks++; if (if3.bad_addr !== bad_exp) begin errors++; $display("FAIL rnd_bad[%0d]: got %b expected %b", c, if3.bad_addr, bad_exp); end
            bad_exp = 1'b0;
            if (c < 300) begin
                if3.adp_send_val = 1'($urandom_range(0, 1));
                if3.adp_send_msg = 6'($urandom_range(0, 63));
                if3.req_send_rdy = 3'($urandom_range(0, 7));
            end else begin
                if3.adp_send_val = 1'b0;
                if3.req_send_rdy = 3'b111;
            end
            #1;
            exp_val = (q.size() > 0) ? 3'(1 << q[0][5:4]) : 3'b000;
            checks++; if (if3.req_send_val !== exp_val) begin errors++; $display("FAIL rnd_val[%0d]: got %b expected %b", c, if3.req_send_val, exp_val); end
            if (q.size() > 0 && if3.req_send_val !== 3'b000) begin
                checks++; if (if3.req_send_msg !== q[0]) begin errors++; $display("FAIL rnd_msg[%0d]: got %h expected %h", c, if3.req_send_msg, q[0]); end
                if ((if3.req_send_val & if3.req_send_rdy) != 3'b000) void'(q.pop_front());
            end
            if (if3.adp_send_val && if3.adp_send_rdy) begin
                if (if3.adp_send_msg[5:4] < 2'd3) q.push_back(if3.adp_send_msg);
                else bad_exp = 1'b1;
            end
            @(posedge clk); #1;
        end
        checks++; if (q.size() != 0) begin errors++; $display("FAIL rnd_leftover: got %0d queued expected 0", q.size()); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        init_inputs();
        test_reset();
        test_round_robin();
        test_tagging();
        test_backpressure();
        test_routing();
        test_reset_midop();
        test_bad_addr();
        test_random_scoreboard();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
